// File: rtl/uart_word_tx.sv
// uart_word_tx: queues 32-bit words in a small FIFO and sends each one as
// four UART bytes, least-significant byte first. Every byte has a start bit,
// eight data bits (LSB first) and a stop bit.
//
// Optional feature macro: UART_TX_PARITY_EN. When it is defined, an even
// parity bit (XOR of the eight data bits) goes between the last data bit and
// the stop bit. When it is undefined, frames are plain 8N1.
//
// Handshake: the producer holds wdata stable while wvalid is high. A word is
// accepted at a rising clock edge when wvalid && wready are both high.
// wready is !full and comes straight from the occupancy count. A push into a
// full FIFO is refused, even if the FSM pops in the same cycle.
//
// state_dbg exposes the FSM state encoding:
// 0 = IDLE, 1 = START, 2 = DATA, 3 = PARITY, 4 = STOP.

module uart_word_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [31:0]                   wdata,
  input  logic                          wvalid,
  output logic                          wready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_n;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Transmit FSM
  state_t        state;
  state_t        state_n;
  logic [BW-1:0] baud;
  logic [BW-1:0] baud_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_n;
  logic [1:0]    byte_idx;
  logic [1:0]    byte_n;
  logic [31:0]   shift;
  logic          tx_bit;
  logic          baud_done;

`ifdef UART_TX_PARITY_EN
  logic [7:0]    cur_byte;
  assign cur_byte = shift[{byte_idx, 3'b000} +: 8];
`endif

  assign full       = (count_q == FULL_COUNT);
  assign empty      = (count_q == '0);
  assign wready     = !full;
  assign push       = wvalid && !full;
  assign fifo_count = count_q;
  assign busy       = (state != S_IDLE) || (count_q != '0);
  assign state_dbg  = state;
  assign baud_done  = (baud == BAUD_LAST);

  // FIFO data array; words are written on accepted pushes only
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Occupancy: a simultaneous push and pop leaves the count unchanged
  always_comb begin
    count_n = count_q;
    case ({push, pop})
      2'b10:   count_n = count_q + (AW + 1)'(1);
      2'b01:   count_n = count_q - (AW + 1)'(1);
      default: count_n = count_q;
    endcase
  end

  // FIFO pointers and count; the pointers wrap because the depth is a power of two
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count_q <= count_n;
    end
  end

  // Next-state logic, counters, pop request and the bit value for the txd flop
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    pop     = 1'b0;
    tx_bit  = 1'b1;
    case (state)
      S_IDLE: begin
        tx_bit = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          state_n = S_START;
          byte_n  = 2'd0;
          baud_n  = '0;
        end
      end
      S_START: begin
        tx_bit = 1'b0;
        if (baud_done) begin
          baud_n  = '0;
          bit_n   = 3'd0;
          state_n = S_DATA;
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      S_DATA: begin
        tx_bit = shift[{byte_idx, bit_idx}];
        if (baud_done) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_bit = ^cur_byte;
        if (baud_done) begin
          baud_n  = '0;
          state_n = S_STOP;
        end else begin
          baud_n = baud + BW'(1);
        end
      end
`endif
      S_STOP: begin
        tx_bit = 1'b1;
        if (baud_done) begin
          baud_n = '0;
          if (byte_idx != 2'd3) begin
            byte_n  = byte_idx + 2'd1;
            state_n = S_START;
          end else if (!empty) begin
            // Chain straight into the next word with no idle gap
            pop     = 1'b1;
            byte_n  = 2'd0;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        baud_n  = '0;
        bit_n   = 3'd0;
        byte_n  = 2'd0;
      end
    endcase
  end

  // State, counters, the word register and the txd flop. txd trails the
  // state by one clock, so every bit on the line still lasts CLKS_PER_BIT cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      baud     <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 2'd0;
      shift    <= '0;
      txd      <= 1'b1;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      txd      <= tx_bit;
      if (pop) begin
        shift <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=8.
// It uses directed words. A serial receiver task rebuilds each word from txd
// and compares it against a queue of the words the bench accepted.
// Build with UART_TX_PARITY_EN defined to also cover the parity bit.

module tb_uart_word_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int BYTE_CYC = FRAME_BITS * CPB;
  localparam int WORD_CYC = 4 * BYTE_CYC;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] wdata = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic        txd;
  logic        busy;
  logic [3:0]  fifo_count;
  logic [2:0]  state_dbg;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          prev_start = -1;
  int          t_acc;
  int          n_wait;
  int          zero_seen;
  int          busy_seen;
  logic [31:0] exp_q[$];

  uart_word_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wdata     (wdata),
    .wvalid    (wvalid),
    .wready    (wready),
    .txd       (txd),
    .busy      (busy),
    .fifo_count(fifo_count),
    .state_dbg (state_dbg)
  );

  // Clock and a cycle counter (cyc == number of rising edges so far)
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Call at a falling edge. Leaves at the falling edge after the accepting edge.
  task automatic push_word(input logic [31:0] w);
    int n;
    n = 0;
    wdata  = w;
    wvalid = 1'b1;
    while (!wready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 32'(wready), 32'd1);
    @(posedge clk);
    exp_q.push_back(w);
    @(negedge clk);
    wvalid = 1'b0;
  endtask

  // Receives one serial byte. It samples at falling edges, one cycle into each bit.
  task automatic rx_byte(output logic [7:0] b, output logic par, output logic stop);
    int n;
    n   = 0;
    b   = '0;
    par = 1'b0;
    while (txd !== 1'b0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("rx_start_seen", 32'(txd), 32'd0);
    if (prev_start >= 0) check("byte_gap", 32'(cyc - prev_start), 32'(BYTE_CYC));
    prev_start = cyc;
    @(negedge clk);
    check("start_bit", 32'(txd), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = txd;
    end
`ifdef UART_TX_PARITY_EN
    repeat (CPB) @(negedge clk);
    par = txd;
`endif
    repeat (CPB) @(negedge clk);
    stop = txd;
  endtask

  // Rebuilds a word from four bytes and scores it against the expected queue
  task automatic rx_word(input string tag);
    logic [31:0] got;
    logic [31:0] want;
    logic [7:0]  b;
    logic [3:0]  pars;
    logic        par;
    logic        stop;
    got  = '0;
    pars = '0;
    for (int k = 0; k < 4; k++) begin
      rx_byte(b, par, stop);
      got[8*k +: 8] = b;
      pars[k] = par;
      check("stop_bit", 32'(stop), 32'd1);
    end
    check("exp_available", 32'(exp_q.size() != 0), 32'd1);
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check(tag, got, want);
`ifdef UART_TX_PARITY_EN
    for (int k = 0; k < 4; k++) begin
      check("parity_bit", 32'(pars[k]), 32'(^want[8*k +: 8]));
    end
`else
    check("no_parity_bits", 32'(pars), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rstn = 1'b1;

    // Idle for 20 cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_txd", 32'(txd), 32'd1);
      check("idle_wready", 32'(wready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_count", 32'(fifo_count), 32'd0);
    end

    // A single word: latency, byte order and when busy falls
    prev_start = -1;
    push_word(32'h1234_5678);
    t_acc = cyc;
    check("acc_count", 32'(fifo_count), 32'd1);
    check("acc_txd", 32'(txd), 32'd1);
    check("acc_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("pop_count", 32'(fifo_count), 32'd0);
    check("pop_txd", 32'(txd), 32'd1);
    @(negedge clk);
    check("first_fall", 32'(txd), 32'd0);
    check("fall_delay", 32'(cyc - t_acc), 32'd2);
    rx_word("word_single");
    n_wait = 0;
    while (cyc < t_acc + WORD_CYC && n_wait < 100) begin
      @(negedge clk);
      n_wait++;
    end
    check("busy_before_end", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_after_end", 32'(busy), 32'd0);
    check("end_state", 32'(state_dbg), 32'd0);
    check("end_txd", 32'(txd), 32'd1);

    // Nine words back-to-back, then one extra push held while the FIFO is full
    repeat (5) @(negedge clk);
    prev_start = -1;
    fork
      begin
        for (int i = 0; i < 9; i++) push_word(32'(i));
        check("full_count", 32'(fifo_count), 32'd8);
        check("full_wready", 32'(wready), 32'd0);
        wdata  = 32'hA5A5_0009;
        wvalid = 1'b1;
        n_wait = 0;
        while (fifo_count == 4'd8 && n_wait < 400) begin
          @(negedge clk);
          n_wait++;
        end
        check("refused_at_pop", 32'(fifo_count), 32'd7);
        check("ready_after_pop", 32'(wready), 32'd1);
        @(posedge clk);
        exp_q.push_back(32'hA5A5_0009);
        @(negedge clk);
        wvalid = 1'b0;
        check("retry_count", 32'(fifo_count), 32'd8);
      end
      begin
        for (int i = 0; i < 10; i++) rx_word("word_b2b");
      end
    join
    n_wait = 0;
    while (busy && n_wait < 100) begin
      @(negedge clk);
      n_wait++;
    end
    check("b2b_drained", 32'(busy), 32'd0);

`ifdef UART_TX_PARITY_EN
    // Parity: 0xFF gives 0 on every byte; 0x01 gives 1 on byte 0 only
    repeat (5) @(negedge clk);
    prev_start = -1;
    push_word(32'h0000_00FF);
    rx_word("word_par_ff");
    push_word(32'h0000_0001);
    rx_word("word_par_01");
    repeat (5) @(negedge clk);
`endif

    // Reset in the middle of byte 1, data bit 3, with three words queued
    repeat (5) @(negedge clk);
    prev_start = -1;
    push_word(32'hFFFF_F7FF);
    t_acc = cyc;
    push_word(32'h1111_1111);
    push_word(32'h2222_2222);
    push_word(32'h3333_3333);
    n_wait = 0;
    while (cyc < t_acc + 2 + BYTE_CYC + 4 * CPB + 1 && n_wait < 200) begin
      @(negedge clk);
      n_wait++;
    end
    check("mid_bit_txd", 32'(txd), 32'd0);
    check("mid_count", 32'(fifo_count), 32'd3);
    check("mid_state", 32'(state_dbg), 32'd2);
    #2 rstn = 1'b0;
    #1;
    check("async_txd", 32'(txd), 32'd1);
    check("async_count", 32'(fifo_count), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_wready", 32'(wready), 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    zero_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) zero_seen++;
      if (busy !== 1'b0) busy_seen++;
    end
    check("post_rst_txd_low_cycles", 32'(zero_seen), 32'd0);
    check("post_rst_busy_cycles", 32'(busy_seen), 32'd0);
    check("post_rst_count", 32'(fifo_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
